// File: rtl/vga_pkg.sv
// Shared constants and read-side FSM encoding for the VGA framebuffer write path.
// Framebuffer is 160x120 pixels, addressed linearly as row*FB_COLS + col.
package vga_pkg;

    localparam int unsigned FB_COLS       = 160;
    localparam int unsigned FB_ROWS       = 120;
    localparam int unsigned FB_SIZE       = FB_COLS * FB_ROWS;
    localparam int unsigned FB_ADDR_W     = 15;
    localparam int unsigned PIX_W_DEFAULT = 8;

    // Read-side FSM: IDLE (nothing held), WAIT (entries held, no write issued), WRITE (fb_we high)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_WRITE = 2'b10
    } rd_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding buffered pixel writes.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   push_i, pop_i    enqueue wdata_i / dequeue head (ignored when full / empty)
//   wdata_i, rdata_o entry in, head entry out (combinational from storage)
//   full_o, empty_o  combinational status from the registered count
//   count_o          number of entries held, 0..DEPTH
module pixel_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 23
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [DW-1:0]           wdata_i,
    output logic [DW-1:0]           rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guards keep the count inside 0..DEPTH regardless of caller behaviour
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer/count next state; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/vga_write_buffer.sv
// Buffers CPU pixel writes and drains them into the framebuffer RAM port
// whenever scan-out grants access.
// Optional feature macro: VGA_BOUNDS_CHECK_EN (drop and flag addresses >= FB_SIZE).
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   wr_req/addr/data  one-cycle pixel-write request from the register bank
//   busy              FIFO full (combinational), CPU stalls while high
//   fb_grant          framebuffer RAM port available this cycle
//   fb_we/addr/wdata  registered framebuffer write port
//   pending           entries currently held
//   ovf, oob          sticky drop flags (overflow, out-of-range), cleared by flag_clr
module vga_write_buffer
    import vga_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PIX_W      = PIX_W_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_req,
    input  logic [FB_ADDR_W-1:0]           wr_addr,
    input  logic [15:0]                    wr_data,
    output logic                           busy,
    input  logic                           fb_grant,
    output logic                           fb_we,
    output logic [FB_ADDR_W-1:0]           fb_addr,
    output logic [PIX_W-1:0]               fb_wdata,
    output logic [$clog2(FIFO_DEPTH):0]    pending,
    output logic                           ovf,
    output logic                           oob,
    input  logic                           flag_clr
);

    localparam int unsigned ENT_W = FB_ADDR_W + PIX_W;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    // Only the low PIX_W bits of wr_data are stored
    if (PIX_W < 16) begin : g_unused_data
        logic unused_data;
        assign unused_data = ^wr_data[15:PIX_W];
    end

    rd_state_e            state_q, state_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]     fb_wdata_q, fb_wdata_d;
    logic                 ovf_q, ovf_d;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENT_W-1:0]     head;

    assign busy = fifo_full;

`ifdef VGA_BOUNDS_CHECK_EN
    logic in_range;
    logic oob_q, oob_d;

    assign in_range = (wr_addr < FB_ADDR_W'(FB_SIZE));
    assign push     = wr_req && !fifo_full && in_range;
`else
    assign push     = wr_req && !fifo_full;
`endif

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({wr_addr, wr_data[PIX_W-1:0]}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending)
    );

    // Read side: pop on grant, present the head on the write port next cycle
    always_comb begin
        state_d    = state_q;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        pop        = 1'b0;
        if (!fifo_empty && fb_grant) begin
            pop                     = 1'b1;
            state_d                 = ST_WRITE;
            {fb_addr_d, fb_wdata_d} = head;
        end else if (!fifo_empty || push) begin
            state_d = ST_WAIT;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Sticky flags: a set event on the same edge wins over flag_clr
    always_comb begin
        ovf_d = ovf_q;
        if (wr_req && fifo_full) begin
            ovf_d = 1'b1;
        end else if (flag_clr) begin
            ovf_d = 1'b0;
        end
`ifdef VGA_BOUNDS_CHECK_EN
        oob_d = oob_q;
        if (wr_req && !in_range) begin
            oob_d = 1'b1;
        end else if (flag_clr) begin
            oob_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef VGA_BOUNDS_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= oob_d;
        end
    end

    assign oob = oob_q;
`else
    assign oob = 1'b0;
`endif

    // Write strobe is a decode of the registered state, so reset drops it at once
    assign fb_we    = (state_q == ST_WRITE);
    assign fb_addr  = fb_addr_q;
    assign fb_wdata = fb_wdata_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_vga_write_buffer.sv
// Bench for vga_write_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based reference of the buffer behaviour.
module tb_vga_write_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [14:0]   wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          fb_grant;
    logic          fb_we;
    logic [14:0]   fb_addr;
    logic [PW-1:0] fb_wdata;
    logic [CW-1:0] pending;
    logic          ovf;
    logic          oob;
    logic          flag_clr;

    always #5 clk = ~clk;

    vga_write_buffer #(
        .FIFO_DEPTH (DEPTH),
        .PIX_W      (PW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .fb_grant (fb_grant),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_wdata (fb_wdata),
        .pending  (pending),
        .ovf      (ovf),
        .oob      (oob),
        .flag_clr (flag_clr)
    );

    typedef struct packed {
        logic [14:0]   a;
        logic [PW-1:0] d;
    } ent_t;

    // Reference state
    ent_t          mq[$];
    logic          m_we;
    logic [14:0]   m_addr;
    logic [PW-1:0] m_data;
    logic          m_ovf;
    logic          m_oob;

    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ovf  = 1'b0;
        m_oob  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".fb_we"},    32'(fb_we),    32'(m_we));
        check({tag, ".fb_addr"},  32'(fb_addr),  32'(m_addr));
        check({tag, ".fb_wdata"}, 32'(fb_wdata), 32'(m_data));
        check({tag, ".pending"},  32'(pending),  32'(mq.size()));
        check({tag, ".busy"},     32'(busy),     32'(mq.size() == DEPTH));
        check({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
        check({tag, ".oob"},      32'(oob),      32'(m_oob));
    endtask

    // One clock: apply inputs, advance the reference by one edge, compare after the edge
    task automatic cycle(input string tag, input logic req, input logic [14:0] addr,
                         input logic [15:0] data, input logic grant, input logic clr);
        logic full;
        logic inr;
        ent_t h;
        wr_req   = req;
        wr_addr  = addr;
        wr_data  = data;
        fb_grant = grant;
        flag_clr = clr;
        full = (mq.size() == DEPTH);
`ifdef VGA_BOUNDS_CHECK_EN
        inr = (addr < 15'd19200);
`else
        inr = 1'b1;
`endif
        if (grant && mq.size() > 0) begin
            h      = mq.pop_front();
            m_we   = 1'b1;
            m_addr = h.a;
            m_data = h.d;
        end else begin
            m_we = 1'b0;
        end
        if (req && !full && inr) begin
            mq.push_back({addr, data[PW-1:0]});
        end
        if (req && full)     m_ovf = 1'b1;
        else if (clr)        m_ovf = 1'b0;
        if (req && !inr)     m_oob = 1'b1;
        else if (clr)        m_oob = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        fb_grant = 1'b0;
        flag_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b0;

        // Single write at row 2, col 1
        cycle("single_push", 1'b1, 15'd321, 16'h00E3, 1'b1, 1'b0);
        check("single_no_we_yet", 32'(fb_we), 32'd0);
        cycle("single_issue", 1'b0, 15'd0, 16'h0, 1'b1, 1'b0);
        check("single_we",    32'(fb_we),    32'd1);
        check("single_addr",  32'(fb_addr),  32'd321);
        check("single_data",  32'(fb_wdata), 32'hE3);
        check("single_empty", 32'(pending),  32'd0);
        cycle("single_after", 1'b0, 15'd0, 16'h0, 1'b1, 1'b0);
        check("single_we_low", 32'(fb_we),   32'd0);
        check("single_hold",  32'(fb_addr),  32'd321);

        // Fill with no grant, fifth write overflows
        for (int i = 0; i < 5; i++) begin
            cycle("fill", 1'b1, 15'(100 + i), 16'(16'h10 + i), 1'b0, 1'b0);
            if (i == 3) check("fill_busy4", 32'(busy), 32'd1);
        end
        check("fill_ovf",     32'(ovf),     32'd1);
        check("fill_pending", 32'(pending), 32'(DEPTH));
        for (int i = 0; i < 4; i++) begin
            cycle("drain", 1'b0, 15'd0, 16'h0, 1'b1, 1'b0);
            check("drain_we",   32'(fb_we),    32'd1);
            check("drain_addr", 32'(fb_addr),  32'(100 + i));
            check("drain_data", 32'(fb_wdata), 32'(16'h10 + i));
            if (i == 0) check("drain_busy_low", 32'(busy), 32'd0);
        end

        // Flag clear, then clear colliding with an overflow drop
        cycle("clr", 1'b0, 15'd0, 16'h0, 1'b0, 1'b1);
        check("clr_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) cycle("refill", 1'b1, 15'(200 + i), 16'(16'h20 + i), 1'b0, 1'b0);
        cycle("clr_vs_set", 1'b1, 15'd250, 16'h55, 1'b0, 1'b1);
        check("clr_vs_set_ovf", 32'(ovf), 32'd1);
        cycle("clr2", 1'b0, 15'd0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle("part_drain", 1'b0, 15'd0, 16'h0, 1'b1, 1'b0);
        check("part_pending", 32'(pending), 32'd2);

        // Push and pop on the same edge keep occupancy constant
        for (int i = 0; i < 10; i++) begin
            cycle("pushpop", 1'b1, 15'(300 + i), 16'(16'h40 + i), 1'b1, 1'b0);
            check("pushpop_pending", 32'(pending), 32'd2);
        end
        check("pushpop_ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 3; i++) cycle("pp_drain", 1'b0, 15'd0, 16'h0, 1'b1, 1'b0);

        // Address bounds
        cycle("oob_hi", 1'b1, 15'd19200, 16'h0077, 1'b0, 1'b0);
`ifdef VGA_BOUNDS_CHECK_EN
        check("oob_hi_oob",     32'(oob),     32'd1);
        check("oob_hi_pending", 32'(pending), 32'd0);
`else
        check("oob_hi_oob",     32'(oob),     32'd0);
        check("oob_hi_pending", 32'(pending), 32'd1);
`endif
        cycle("oob_last", 1'b1, 15'd19199, 16'h0088, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("oob_drain", 1'b0, 15'd0, 16'h0, 1'b1, 1'b0);
        check("oob_last_addr", 32'(fb_addr), 32'd19199);
        cycle("oob_clr", 1'b0, 15'd0, 16'h0, 1'b0, 1'b1);

        // Reset in the middle of a drain
        for (int i = 0; i < 4; i++) cycle("rst_fill", 1'b1, 15'(400 + i), 16'(16'h60 + i), 1'b0, 1'b0);
        cycle("rst_pop", 1'b0, 15'd0, 16'h0, 1'b1, 1'b0);
        check("rst_pre_we", 32'(fb_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_async_we", 32'(fb_we), 32'd0);
        check_outputs("rst_async");
        fb_grant = 1'b0;
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("rst_release");

        // Random traffic, biased toward the address boundary
        for (int n = 0; n < 400; n++) begin
            logic [14:0] ra;
            if ($urandom_range(0, 3) == 0) ra = 15'($urandom_range(19190, 19210));
            else                           ra = 15'($urandom_range(0, 32767));
            cycle("rand", 1'($urandom_range(0, 9) < 6), ra, 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
